// File: rtl/burst_memory_if.sv
// Request/response bundle between a memory master (fetch, mem stage, loader)
// and burst_memory.
interface burst_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      enable;
    logic                      rw;
    logic [ADDR_WIDTH-1:0]     address;
    logic [1:0]                access_size;
    logic [DATA_WIDTH-1:0]     data_in;
    logic [DATA_WIDTH/8-1:0]   byte_en;
    logic                      busy;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      data_valid;
    logic                      error;

    modport master (
        output enable, rw, address, access_size, data_in, byte_en,
        input  busy, data_out, data_valid, error
    );

    modport slave (
        input  enable, rw, address, access_size, data_in, byte_en,
        output busy, data_out, data_valid, error
    );
endinterface

// File: rtl/burst_memory.sv
// Word-array main memory at BASE_ADDR serving single-word and 4/8/16-beat
// incrementing bursts with byte-enable writes and out-of-range rejection.
module burst_memory #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 262144,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8002_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    burst_memory_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic [3:0]              len_m1;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word_off;
    logic [ADDR_WIDTH-1:0]   last_word;
    logic                    in_range;
    logic [IDX_W-1:0]        idx0;
    logic                    wr_en, rd_en;
    logic [IDX_W-1:0]        acc_idx;

    always_comb begin
        unique case (bus.access_size)
            2'b00:   len_m1 = 4'd0;
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            default: len_m1 = 4'd15;
        endcase
    end

    // Word offset of beat 0 cannot exceed 2^(ADDR_WIDTH-2), so adding the
    // burst length never overflows and bursts are checked without wrapping.
    assign offset    = bus.address - BASE_ADDR;
    assign word_off  = offset >> 2;
    assign last_word = word_off + ADDR_WIDTH'(len_m1);
    assign in_range  = (bus.address >= BASE_ADDR) &&
                       (last_word < ADDR_WIDTH'(DEPTH_WORDS));
    assign idx0      = word_off[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        acc_idx = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    if (!in_range) begin
                        error_d = 1'b1;
                    end else begin
                        acc_idx = idx0;
                        wr_en   = !bus.rw;
                        rd_en   = bus.rw;
                        valid_d = bus.rw;
                        cnt_d   = len_m1;
                        idx_d   = idx0 + IDX_W'(1);
                        if (len_m1 != 4'd0)
                            state_d = bus.rw ? READ_BURST : WRITE_BURST;
                    end
                end
            end
            WRITE_BURST, READ_BURST: begin
                wr_en   = (state_q == WRITE_BURST);
                rd_en   = (state_q == READ_BURST);
                valid_d = rd_en;
                cnt_d   = cnt_q - 4'd1;
                idx_d   = idx_q + IDX_W'(1);
                if (cnt_q == 4'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            error_q <= error_d;
            if (rd_en)
                data_out_q <= mem[acc_idx];
        end
    end

    // Storage is never reset; writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (wr_en && reset_n) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.byte_en[b])
                    mem[acc_idx][8*b +: 8] <= bus.data_in[8*b +: 8];
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.error      = error_q;
endmodule
